fpu_cvt_sequencer: RTL

FPU_CVT_SEQUENCER -- requirements
Module: fpu_cvt_sequencer

---
 rtl/fpu_cvt_pkg.sv | 32 +++
 rtl/rr_arb2.sv | 60 ++++++
 rtl/fpu_cvt_sequencer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/fpu_cvt_pkg.sv
// -----------------------------------------------------------------------------
// fpu_cvt_pkg
//   Shared definitions for the float-to-unsigned conversion sequencer:
//   sequencer state encoding, default WAIT timeout, response record and a
//   small saturating-increment helper for the 8-bit timeout counter.
// -----------------------------------------------------------------------------
package fpu_cvt_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // Default maximum number of WAIT cycles before the operation is aborted
    localparam int unsigned TIMEOUT_DEFAULT = 63;

    // Response record presented on the rsp_* port group
    typedef struct packed {
        logic        id;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    // 8-bit increment that sticks at all-ones instead of wrapping
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
//   Two-way round-robin arbiter. The grant is combinational from the request
//   vector and the last-served pointer; the pointer only moves when the
//   served operation is reported complete, so a requester that was granted
//   keeps "last served" status for the whole duration of its operation.
//
// Ports
//   i_clk      clock
//   i_rst      asynchronous active-high reset (pointer -> 1)
//   i_req      request vector
//   i_en       grant enable (arbiter may only grant while enabled)
//   i_done     completion of the served operation (pointer update)
//   i_done_id  index of the requester whose operation completed
//   o_gnt      one-hot grant (all-zero when disabled or no request)
//   o_gnt_id   index of the granted requester (valid when o_gnt != 0)
// -----------------------------------------------------------------------------
module rr_arb2 (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_req,
    input  logic       i_en,
    input  logic       i_done,
    input  logic       i_done_id,
    output logic [1:0] o_gnt,
    output logic       o_gnt_id
);

    logic r_last;
    logic w_pick;

    // Pointer resets to 1 so that requester 0 wins the first contention
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_last <= 1'b1;
        end else if (i_done) begin
            r_last <= i_done_id;
        end
    end

    // On contention the requester not served last wins; otherwise whichever
    // single requester is active.
    always_comb begin
        w_pick = 1'b0;
        if (i_req == 2'b11) begin
            w_pick = ~r_last;
        end else begin
            w_pick = i_req[1];
        end
    end

    always_comb begin
        o_gnt    = '0;
        o_gnt_id = w_pick;
        if (i_en && (|i_req)) begin
            o_gnt = w_pick ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/fpu_cvt_sequencer.sv
// -----------------------------------------------------------------------------
// fpu_cvt_sequencer
//   Shares one float-to-unsigned-int converter between two requesters.
//   A request is accepted in IDLE (one-cycle req_ready pulse), its operand
//   and rounding mode are latched onto cvt_a/cvt_rm, the converter is
//   released from hold for LAUNCH and WAIT, and the result (or a timeout
//   error) is held on rsp_* until the consumer accepts it.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   req_valid[1:0]      per-requester request
//   req_ready[1:0]      one-hot accept pulse (IDLE only)
//   req_a0/req_a1       IEEE-754 single operands
//   req_rm0/req_rm1     rounding modes
//   cvt_a, cvt_rm       operand / rounding mode to the converter
//   cvt_rst             converter hold (1 = parked in unpack)
//   cvt_z, cvt_z_stb    converter result and one-cycle result strobe
//   rsp_valid/ready     response handshake
//   rsp_id              requester index of the response
//   rsp_data            conversion result (0 on timeout)
//   rsp_err             timeout flag
//   busy                high whenever the sequencer is not IDLE
// -----------------------------------------------------------------------------
module fpu_cvt_sequencer
    import fpu_cvt_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [31:0] req_a0,
    input  logic [31:0] req_a1,
    input  logic [2:0]  req_rm0,
    input  logic [2:0]  req_rm1,
    output logic [31:0] cvt_a,
    output logic [2:0]  cvt_rm,
    output logic        cvt_rst,
    input  logic [31:0] cvt_z,
    input  logic        cvt_z_stb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        busy
);

    // The counter is cleared in LAUNCH and reads k-1 in the k-th WAIT cycle,
    // so comparing against TIMEOUT-1 aborts after exactly TIMEOUT WAIT cycles.
    localparam logic [7:0] TO_LIM = 8'(TIMEOUT - 1);

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [31:0] r_cvt_a;
    logic [2:0]  r_cvt_rm;
    logic        r_cvt_rst;
    logic        r_busy;
    logic        r_id;
    logic        r_rsp_valid;
    rsp_t        r_rsp;

    logic        w_arb_en;
    logic [1:0]  w_gnt;
    logic        w_gnt_id;
    logic        w_done;

    // Accepts only happen in IDLE; reset also masks the combinational pulse
    // so req_ready is forced low while rst is asserted.
    assign w_arb_en = (r_state == ST_IDLE) && !rst;
    assign w_done   = (r_state == ST_RESP) && rsp_ready;

    rr_arb2 u_arb (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_req     (req_valid),
        .i_en      (w_arb_en),
        .i_done    (w_done),
        .i_done_id (r_rsp.id),
        .o_gnt     (w_gnt),
        .o_gnt_id  (w_gnt_id)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_cvt_a     <= '0;
            r_cvt_rm    <= '0;
            r_cvt_rst   <= 1'b1;
            r_busy      <= 1'b0;
            r_id        <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|w_gnt) begin
                        r_cvt_a   <= w_gnt_id ? req_a1  : req_a0;
                        r_cvt_rm  <= w_gnt_id ? req_rm1 : req_rm0;
                        r_id      <= w_gnt_id;
                        r_cvt_rst <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= ST_LAUNCH;
                    end
                end

                ST_LAUNCH: begin
                    r_cnt   <= '0;
                    r_state <= ST_WAIT;
                end

                ST_WAIT: begin
                    r_cnt <= sat_inc8(r_cnt);
                    // Strobe has priority over a timeout in the same cycle
                    if (cvt_z_stb) begin
                        r_rsp       <= '{id: r_id, data: cvt_z, err: 1'b0};
                        r_rsp_valid <= 1'b1;
                        r_cvt_rst   <= 1'b1;
                        r_state     <= ST_RESP;
                    end else if (r_cnt >= TO_LIM) begin
                        r_rsp       <= '{id: r_id, data: 32'h0, err: 1'b1};
                        r_rsp_valid <= 1'b1;
                        r_cvt_rst   <= 1'b1;
                        r_state     <= ST_RESP;
                    end
                end

                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready = w_gnt;
    assign cvt_a     = r_cvt_a;
    assign cvt_rm    = r_cvt_rm;
    assign cvt_rst   = r_cvt_rst;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp.id;
    assign rsp_data  = r_rsp.data;
    assign rsp_err   = r_rsp.err;
    assign busy      = r_busy;

endmodule
